// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg: shared types and constants for the main-memory port arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int NUM_PORTS     = 2;
  localparam int BURST_LEN_DEF = 8;

  typedef logic port_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  function automatic logic [NUM_PORTS-1:0] onehot(input port_t p);
    logic [NUM_PORTS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick: two-way winner selection; MEM_PORT_ARB_RR_EN enables round-robin.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
`ifdef MEM_PORT_ARB_RR_EN
  input  port_t                ptr,
`endif
  output logic                 valid,
  output port_t                win
);

  always_comb begin
    valid = |req;
`ifdef MEM_PORT_ARB_RR_EN
    // On contention the pointer decides; otherwise the lone requester wins.
    if (req[0] && req[1]) begin
      win = ptr;
    end else begin
      win = req[1];
    end
`else
    win = !req[0];
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter: per-transaction arbiter of one main-memory port between
// two requesters. Build macro MEM_PORT_ARB_RR_EN selects round-robin priority.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS-1:0]              burst_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_W-1:0]                 rdata_o,
  output logic [3:0]                        beat_o,
  output logic [NUM_PORTS-1:0]              done_o,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic                              mem_ready,
  input  logic                              mem_done,
  input  logic [DATA_W-1:0]                 mem_rdata
);

  localparam logic [3:0] c_burst_last = 4'(BURST_LEN - 1);

  arb_state_t          r_state, w_state_nxt;
  port_t               r_port, w_port_nxt;
  logic                r_we, w_we_nxt;
  logic                r_burst, w_burst_nxt;
  logic [ADDR_W-1:0]   r_base, w_base_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [3:0]          r_beat, w_beat_nxt;
  logic [3:0]          w_last;

  logic [NUM_PORTS-1:0] w_gnt_nxt, w_rvalid_nxt, w_done_nxt;
  logic [DATA_W-1:0]    w_rdata_nxt;
  logic [3:0]           w_beat_o_nxt;
  logic                 w_mem_req_nxt, w_mem_we_nxt;
  logic [ADDR_W-1:0]    w_mem_addr_nxt;
  logic [DATA_W-1:0]    w_mem_wdata_nxt;

  logic  w_pick_valid;
  port_t w_pick;

`ifdef MEM_PORT_ARB_RR_EN
  port_t r_ptr, w_ptr_nxt;
`endif

  rr_pick u_pick (
    .req   (req_i),
`ifdef MEM_PORT_ARB_RR_EN
    .ptr   (r_ptr),
`endif
    .valid (w_pick_valid),
    .win   (w_pick)
  );

  // Writes and plain reads are single-beat; only a read burst runs long.
  assign w_last = (!r_we && r_burst) ? c_burst_last : 4'd0;

  always_comb begin
    w_state_nxt     = r_state;
    w_port_nxt      = r_port;
    w_we_nxt        = r_we;
    w_burst_nxt     = r_burst;
    w_base_nxt      = r_base;
    w_wdata_nxt     = r_wdata;
    w_beat_nxt      = r_beat;
    w_gnt_nxt       = '0;
    w_rvalid_nxt    = '0;
    w_done_nxt      = '0;
    w_rdata_nxt     = rdata_o;
    w_beat_o_nxt    = beat_o;
    w_mem_req_nxt   = mem_req;
    w_mem_we_nxt    = mem_we;
    w_mem_addr_nxt  = mem_addr;
    w_mem_wdata_nxt = mem_wdata;
`ifdef MEM_PORT_ARB_RR_EN
    w_ptr_nxt       = r_ptr;
`endif

    case (r_state)
      ARB: begin
        if (w_pick_valid) begin
          w_port_nxt      = w_pick;
          w_we_nxt        = we_i[w_pick];
          w_burst_nxt     = burst_i[w_pick];
          w_base_nxt      = addr_i[w_pick];
          w_wdata_nxt     = wdata_i[w_pick];
          w_beat_nxt      = 4'd0;
          w_gnt_nxt       = onehot(w_pick);
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = we_i[w_pick];
          w_mem_addr_nxt  = addr_i[w_pick];
          w_mem_wdata_nxt = wdata_i[w_pick];
          w_state_nxt     = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_ready) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = WAIT;
        end
      end

      WAIT: begin
        if (mem_done) begin
          if (!r_we) begin
            w_rvalid_nxt = onehot(r_port);
            w_rdata_nxt  = mem_rdata;
            w_beat_o_nxt = r_beat;
          end
          if (r_beat < w_last) begin
            // Address arithmetic wraps naturally at ADDR_W bits.
            w_beat_nxt     = r_beat + 4'd1;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = r_base + ADDR_W'(r_beat + 4'd1);
            w_state_nxt    = ISSUE;
          end else begin
            w_done_nxt  = onehot(r_port);
            w_state_nxt = ARB;
`ifdef MEM_PORT_ARB_RR_EN
            w_ptr_nxt   = !r_port;
`endif
          end
        end
      end

      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ARB;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_burst   <= 1'b0;
      r_base    <= '0;
      r_wdata   <= '0;
      r_beat    <= 4'd0;
      gnt_o     <= '0;
      rvalid_o  <= '0;
      done_o    <= '0;
      rdata_o   <= '0;
      beat_o    <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_PORT_ARB_RR_EN
      r_ptr     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_port    <= w_port_nxt;
      r_we      <= w_we_nxt;
      r_burst   <= w_burst_nxt;
      r_base    <= w_base_nxt;
      r_wdata   <= w_wdata_nxt;
      r_beat    <= w_beat_nxt;
      gnt_o     <= w_gnt_nxt;
      rvalid_o  <= w_rvalid_nxt;
      done_o    <= w_done_nxt;
      rdata_o   <= w_rdata_nxt;
      beat_o    <= w_beat_o_nxt;
      mem_req   <= w_mem_req_nxt;
      mem_we    <= w_mem_we_nxt;
      mem_addr  <= w_mem_addr_nxt;
      mem_wdata <= w_mem_wdata_nxt;
`ifdef MEM_PORT_ARB_RR_EN
      r_ptr     <= w_ptr_nxt;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter: directed table-driven bench for mem_port_arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic                             clk = 1'b0;
  logic                             rst = 1'b0;
  logic [NUM_PORTS-1:0]             req_i = '0;
  logic [NUM_PORTS-1:0]             we_i = '0;
  logic [NUM_PORTS-1:0]             burst_i = '0;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_i = '0;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_i = '0;
  logic [NUM_PORTS-1:0]             gnt_o, rvalid_o, done_o;
  logic [DATA_W-1:0]                rdata_o;
  logic [3:0]                       beat_o;
  logic                             mem_req, mem_we;
  logic [ADDR_W-1:0]                mem_addr;
  logic [DATA_W-1:0]                mem_wdata;
  logic                             mem_ready = 1'b1;
  logic                             mem_done = 1'b0;
  logic [DATA_W-1:0]                mem_rdata = '0;

  int          mem_lat  = 0;
  logic        ovr_en   = 1'b0;
  logic [31:0] ovr_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .we_i      (we_i),
    .burst_i   (burst_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .beat_o    (beat_o),
    .done_o    (done_o),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata)
  );

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  // Memory model: returns the word address as data unless overridden.
  initial begin : mem_model
    logic              pend;
    int                cnt;
    logic [ADDR_W-1:0] pa;
    pend = 1'b0;
    cnt  = 0;
    pa   = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_done = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          mem_done  = 1'b1;
          mem_rdata = ovr_en ? ovr_data : {16'h0000, pa};
          pend      = 1'b0;
        end else begin
          cnt--;
        end
      end else if (mem_req && mem_ready && rst) begin
        pend = 1'b1;
        cnt  = mem_lat;
        pa   = mem_addr;
      end
    end
  end

  typedef struct {
    port_t       port;
    logic        we;
    logic        burst;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          stall;
    int          lat;
    logic        ovr_en;
    logic [31:0] ovr;
    int          exp_beats;
    logic [15:0] exp_last_addr;
    logic [31:0] exp_first_rdata;
    logic [31:0] exp_last_rdata;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int          cyc, n_acc, n_rv, extra_gnt, stall_left;
    logic        seen_done;
    logic [15:0] last_addr;
    logic [31:0] first_rd, last_rd, exp_rd;
    mem_lat  = v.lat;
    ovr_en   = v.ovr_en;
    ovr_data = v.ovr;
    @(negedge clk);
    we_i[v.port]    = v.we;
    burst_i[v.port] = v.burst;
    addr_i[v.port]  = v.addr;
    wdata_i[v.port] = v.wdata;
    req_i[v.port]   = 1'b1;
    stall_left      = v.stall;
    mem_ready       = (v.stall == 0);
    @(negedge clk);
    check({tag, " gnt latency"}, gnt_o, onehot(v.port));
    req_i[v.port]   = 1'b0;
    addr_i[v.port]  = ~v.addr;
    wdata_i[v.port] = ~v.wdata;
    we_i[v.port]    = ~v.we;
    n_acc = 0; n_rv = 0; extra_gnt = 0; cyc = 0;
    seen_done = 1'b0; last_addr = '0; first_rd = '0; last_rd = '0;
    while (!seen_done && cyc < 300) begin
      if (cyc > 0 && gnt_o != '0) extra_gnt++;
      if (rvalid_o != '0) begin
        exp_rd = v.ovr_en ? v.ovr : {16'h0000, 16'(v.addr + 16'(n_rv))};
        check({tag, " rvalid port"}, rvalid_o, onehot(v.port));
        check({tag, " beat_o"}, beat_o, 64'(n_rv));
        check({tag, " rdata"}, rdata_o, exp_rd);
        if (n_rv == 0) first_rd = rdata_o;
        last_rd = rdata_o;
        n_rv++;
      end
      if (done_o != '0) begin
        check({tag, " done port"}, done_o, onehot(v.port));
        check({tag, " rvalid with done"}, rvalid_o, v.we ? 2'b00 : onehot(v.port));
        seen_done = 1'b1;
      end
      if (mem_req) begin
        if (!mem_ready) begin
          check({tag, " stall addr"}, mem_addr, v.addr);
          check({tag, " stall wdata"}, mem_wdata, v.wdata);
          stall_left--;
          if (stall_left <= 0) mem_ready = 1'b1;
        end
        if (mem_ready) begin
          check({tag, " mem_addr"}, mem_addr, 16'(v.addr + 16'(n_acc)));
          check({tag, " mem_we"}, mem_we, v.we);
          if (v.we) check({tag, " mem_wdata"}, mem_wdata, v.wdata);
          last_addr = mem_addr;
          n_acc++;
        end
      end
      if (!seen_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " completed in budget"}, seen_done, 1'b1);
    check({tag, " accept count"}, n_acc, v.exp_beats);
    check({tag, " rvalid count"}, n_rv, v.we ? 0 : v.exp_beats);
    check({tag, " last addr"}, last_addr, v.exp_last_addr);
    check({tag, " single grant"}, extra_gnt, 0);
    if (!v.we) begin
      check({tag, " first rdata"}, first_rd, v.exp_first_rdata);
      check({tag, " last rdata"}, last_rd, v.exp_last_rdata);
    end
    mem_ready = 1'b1;
  endtask

  vec_t vecs[6];
  port_t exp_win[4];

  initial begin
    int    cyc, n_acc, bad, nrv;
    logic  seen;
    port_t win;
    logic [NUM_PORTS-1:0] any_pulse;

    //     port  we    burst addr     wdata         stall lat ovr   ovr           beats last     first         last
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0120, 32'h0,        0, 2, 1'b1, 32'hDEADBEEF, 1, 16'h0120, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0FE0, 32'h0,        0, 1, 1'b0, 32'h0,        8, 16'h0FE7, 32'h00000FE0, 32'h00000FE7};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0003, 32'hA5A5A5A5, 5, 1, 1'b0, 32'h0,        1, 16'h0003, 32'h0,        32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'hFFFC, 32'h0,        0, 0, 1'b0, 32'h0,        8, 16'h0003, 32'h0000FFFC, 32'h00000003};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h1234, 32'h12345678, 0, 0, 1'b0, 32'h0,        1, 16'h1234, 32'h0,        32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 32'h0,        0, 3, 1'b0, 32'h0,        1, 16'h00FF, 32'h000000FF, 32'h000000FF};
`ifdef MEM_PORT_ARB_RR_EN
    exp_win = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_win = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset gnt_o", gnt_o, 0);
    check("reset rvalid_o", rvalid_o, 0);
    check("reset done_o", done_o, 0);
    check("reset mem_req", mem_req, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset rdata_o", rdata_o, 0);
    check("reset beat_o", beat_o, 0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during beat 3 of a port-0 burst
    mem_lat = 1; ovr_en = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    we_i[0] = 1'b0; burst_i[0] = 1'b1; addr_i[0] = 16'h0200; req_i[0] = 1'b1;
    n_acc = 0; cyc = 0;
    while (n_acc < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (gnt_o[0]) req_i[0] = 1'b0;
      if (mem_req && mem_ready) n_acc++;
    end
    check("rst-mid reached beat 3", n_acc, 4);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst-mid pulses", {gnt_o, rvalid_o, done_o}, 0);
    check("rst-mid mem_req/we", {mem_req, mem_we}, 0);
    check("rst-mid mem_addr", mem_addr, 0);
    check("rst-mid mem_wdata", mem_wdata, 0);
    check("rst-mid rdata/beat", {rdata_o, beat_o}, 0);
    any_pulse = '0;
    repeat (2) begin
      @(negedge clk);
      any_pulse = any_pulse | done_o | rvalid_o;
    end
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      any_pulse = any_pulse | done_o | rvalid_o | gnt_o;
    end
    check("rst-mid no done or stray response", any_pulse, 0);
    run_txn('{1'b0, 1'b0, 1'b1, 16'h0200, 32'h0, 0, 1, 1'b0, 32'h0, 8, 16'h0207, 32'h00000200, 32'h00000207},
            "restart");

    // Contention from a clean reset (pointer at port 0)
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_lat = 0; mem_ready = 1'b1;
    we_i = 2'b00; burst_i = 2'b10;
    addr_i[0] = 16'h0100; addr_i[1] = 16'h0FE0;
    @(negedge clk);
    req_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      cyc = 0;
      @(negedge clk);
      while (gnt_o == '0 && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check($sformatf("contention grant %0d", t), gnt_o, onehot(exp_win[t]));
      win = gnt_o[1];
      req_i[win] = 1'b0;
      cyc = 0; seen = 1'b0; bad = 0; nrv = 0;
      while (!seen && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (rvalid_o != '0) begin
          nrv++;
          if (rvalid_o != onehot(win)) bad++;
        end
        if (done_o != '0) begin
          seen = 1'b1;
          check($sformatf("contention done %0d", t), done_o, onehot(win));
        end
      end
      check($sformatf("contention completed %0d", t), seen, 1'b1);
      check($sformatf("contention no interleave %0d", t), bad, 0);
      check($sformatf("contention beats %0d", t), nrv, win ? 8 : 1);
      if (t < 3) req_i[win] = 1'b1;
      else req_i = 2'b00;
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
